// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling
// constants and the baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;

  // Sub-bit positions of the three majority-vote samples; the bit is
  // decided at the last of them.
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned den;
    den = baud * OVERSAMPLE;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, restartable
// with a synchronous clear so the first tick lands DIV clocks after it.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, wraps at DIV-1 and restarts on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with input synchronizer, start-bit glitch
// rejection, 2-of-3 majority sampling, framing-error and break reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       IDLE,
  output logic       FRAME_ERR,
  output logic       BREAK
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx: CLK_HZ/(BAUD*OVERSAMPLE) rounds below 1");
  end

  logic       sync_1;
  logic       rx_s;
  logic       clr;
  logic       tick;
  logic       maj;

  rx_state_t  state, state_n;
  logic [3:0] s, s_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] samp, samp_n;
  logic [7:0] sh, sh_n;
  logic [7:0] data_n;
  logic       valid_n, ferr_n, brk_n;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (clr),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= TXD;
      rx_s   <= sync_1;
    end
  end

  // State, sampling datapath and registered output strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      s         <= '0;
      bit_idx   <= '0;
      samp      <= '0;
      sh        <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      BREAK     <= 1'b0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      bit_idx   <= bit_n;
      samp      <= samp_n;
      sh        <= sh_n;
      DATA      <= data_n;
      VALID     <= valid_n;
      FRAME_ERR <= ferr_n;
      BREAK     <= brk_n;
    end
  end

  // Next-state logic: start detection, per-tick sampling and bit decisions.
  always_comb begin
    state_n = state;
    s_n     = s;
    bit_n   = bit_idx;
    samp_n  = samp;
    sh_n    = sh;
    data_n  = DATA;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    brk_n   = 1'b0;
    clr     = 1'b0;
    maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          clr     = 1'b1;
          // s is preset to 1 so the value seen at tick n is n mod 16,
          // putting the decision for bit k at tick 16k+9.
          s_n     = 4'd1;
          bit_n   = '0;
        end
      end

      ST_START, ST_DATA, ST_STOP: begin
        if (tick) begin
          s_n = s + 4'd1;
          if (s == SAMPLE_A) samp_n[0] = rx_s;
          if (s == SAMPLE_B) samp_n[1] = rx_s;
          if (s == SAMPLE_C) begin
            if (state == ST_START) begin
              state_n = maj ? ST_IDLE : ST_DATA;
            end else if (state == ST_DATA) begin
              sh_n  = {maj, sh[7:1]};
              bit_n = bit_idx + 3'd1;
              if (bit_idx == 3'd7) state_n = ST_STOP;
            end else begin
              if (maj) begin
                valid_n = 1'b1;
                data_n  = sh;
                state_n = ST_IDLE;
              end else begin
                if (sh == 8'h00) brk_n  = 1'b1;
                else             ferr_n = 1'b1;
                state_n = ST_WAIT_HIGH;
              end
            end
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign IDLE = (state == ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV=1 (16 clocks per bit). A frame-level model
// predicts every output each cycle from the recorded line history.
module tb_uart_rx;

  logic       CLK;
  logic       RST_N;
  logic       TXD;
  logic [7:0] DATA;
  logic       VALID;
  logic       IDLE;
  logic       FRAME_ERR;
  logic       BREAK;

  uart_rx #(
    .CLK_HZ (1_600_000),
    .BAUD   (100_000)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .TXD       (TXD),
    .DATA      (DATA),
    .VALID     (VALID),
    .IDLE      (IDLE),
    .FRAME_ERR (FRAME_ERR),
    .BREAK     (BREAK)
  );

  localparam int HN = 4096;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic hist [0:HN-1];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Line history: hist[c] is the TXD level driven while cyc == c.
  always @(posedge CLK) begin
    if (cyc < HN) hist[cyc] = TXD;
    cyc = cyc + 1;
  end

  // Strobe log for the directed literal checks.
  int         nvalid, nferr, nbrk;
  int         vcyc, fcyc, bcyc, vfirst_cyc;
  logic [7:0] vdata, vfirst_data;

  always @(negedge CLK) begin
    if (VALID) begin
      nvalid++;
      vcyc  = cyc;
      vdata = DATA;
      if (nvalid == 1) begin
        vfirst_cyc  = cyc;
        vfirst_data = DATA;
      end
    end
    if (FRAME_ERR) begin nferr++; fcyc = cyc; end
    if (BREAK)     begin nbrk++;  bcyc = cyc; end
  end

  // Frame-level model. A line low seen 3 clocks earlier starts a frame;
  // bits are read at their centres; the outcome lands 156 clocks after
  // the line fell (detection + 153).
  int         mstate   = 0;   // 0 waiting, 1 in frame, 2 waiting for high
  int         mfc      = 0;
  int         last_rst = -1;
  int         ev       = 0;   // 0 none, 1 valid, 2 frame error, 3 break
  int         t;
  logic [7:0] mdata    = 8'h00;
  logic [7:0] mbyte;

  always @(negedge CLK) begin
    ev = 0;
    if (!RST_N) begin
      mstate   = 0;
      mdata    = 8'h00;
      last_rst = cyc;
    end else begin
      case (mstate)
        0: if (cyc >= 3 && (cyc - 3) > last_rst && hist[cyc-3] == 1'b0) begin
             mfc    = cyc - 3;
             mstate = 1;
           end
        1: begin
             t = cyc - mfc - 3;
             if (t == 9 && hist[mfc+8] == 1'b1) begin
               mstate = 0;
             end else if (t == 153) begin
               for (int i = 0; i < 8; i++) mbyte[i] = hist[mfc + 16*(i+1) + 8];
               if (hist[mfc+152]) begin
                 ev     = 1;
                 mdata  = mbyte;
                 mstate = 0;
               end else begin
                 ev     = (mbyte == 8'h00) ? 3 : 2;
                 mstate = 2;
               end
             end
           end
        default: if (hist[cyc-3] == 1'b1) mstate = 0;
      endcase
    end
    chk("valid",     int'(VALID),     int'(ev == 1));
    chk("frame_err", int'(FRAME_ERR), int'(ev == 2));
    chk("break",     int'(BREAK),     int'(ev == 3));
    chk("idle",      int'(IDLE),      int'(mstate == 0));
    chk("data",      int'(DATA),      int'(mdata));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clr_log();
    nvalid = 0; nferr = 0; nbrk = 0;
    vcyc = -1; fcyc = -1; bcyc = -1; vfirst_cyc = -1;
    vdata = 8'h00; vfirst_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int fc);
    fc  = cyc;
    TXD = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 8; i++) begin
      TXD = b[i];
      wait_cyc(16);
    end
    TXD = stop;
    wait_cyc(16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int fc, fc2, h;

  initial begin
    RST_N = 1'b0;
    TXD   = 1'b1;
    clr_log();
    wait_cyc(5);
    chk("rst_data", int'(DATA), 8'h00);
    chk("rst_idle", int'(IDLE), 1);
    RST_N = 1'b1;
    wait_cyc(10);

    // Clean byte 0xA5.
    clr_log();
    send_frame(8'hA5, 1'b1, fc);
    wait_cyc(10);
    chk("t1_nvalid",  nvalid, 1);
    chk("t1_latency", vcyc - fc, 156);
    chk("t1_data",    int'(vdata), 8'hA5);
    chk("t1_others",  nferr + nbrk, 0);
    chk("t1_idle",    int'(IDLE), 1);

    // Framing error: 0x55 with stop bit 0, line then held low.
    clr_log();
    send_frame(8'h55, 1'b0, fc);
    wait_cyc(20);
    chk("t4_nferr",   nferr, 1);
    chk("t4_latency", fcyc - fc, 156);
    chk("t4_others",  nvalid + nbrk, 0);
    chk("t4_data",    int'(DATA), 8'hA5);
    chk("t4_idle_lo", int'(IDLE), 0);
    h   = cyc;
    TXD = 1'b1;
    wait_cyc(2);
    chk("t4_idle_h2", int'(IDLE), 0);
    wait_cyc(1);
    chk("t4_idle_h3", int'(IDLE), 1);
    chk("t4_h_delay", cyc - h, 3);
    wait_cyc(10);

    // Back-to-back 0x12, 0x34 with no gap.
    clr_log();
    send_frame(8'h12, 1'b1, fc);
    send_frame(8'h34, 1'b1, fc2);
    wait_cyc(10);
    chk("t2_nvalid", nvalid, 2);
    chk("t2_first",  int'(vfirst_data), 8'h12);
    chk("t2_second", int'(vdata), 8'h34);
    chk("t2_gap",    vcyc - vfirst_cyc, 160);
    chk("t2_lat",    vfirst_cyc - fc, 156);

    // Glitch: 4-clock low pulse.
    clr_log();
    fc  = cyc;
    TXD = 1'b0;
    wait_cyc(4);
    TXD = 1'b1;
    wait_cyc(4);
    chk("t3_idle_mid", int'(IDLE), 0);
    wait_cyc(4);
    chk("t3_idle_back", int'(IDLE), 1);
    wait_cyc(30);
    chk("t3_strobes", nvalid + nferr + nbrk, 0);

    // Break: line low for 20 bit times.
    clr_log();
    fc  = cyc;
    TXD = 1'b0;
    wait_cyc(320);
    chk("t5_nbrk",    nbrk, 1);
    chk("t5_latency", bcyc - fc, 156);
    chk("t5_others",  nvalid + nferr, 0);
    chk("t5_idle_lo", int'(IDLE), 0);
    TXD = 1'b1;
    wait_cyc(3);
    chk("t5_idle_hi", int'(IDLE), 1);
    wait_cyc(10);

    // Reset in the middle of 0xFF, then a clean 0x3C.
    clr_log();
    TXD = 1'b0;
    wait_cyc(16);
    TXD = 1'b1;
    wait_cyc(16*4 + 8);
    chk("t6_busy", int'(IDLE), 0);
    RST_N = 1'b0;
    #1;
    chk("t6_async_data",  int'(DATA), 8'h00);
    chk("t6_async_idle",  int'(IDLE), 1);
    chk("t6_async_valid", int'(VALID), 0);
    chk("t6_async_ferr",  int'(FRAME_ERR), 0);
    wait_cyc(5);
    RST_N = 1'b1;
    wait_cyc(200);
    chk("t6_no_valid", nvalid + nferr + nbrk, 0);
    clr_log();
    send_frame(8'h3C, 1'b1, fc);
    wait_cyc(10);
    chk("t6_nvalid",  nvalid, 1);
    chk("t6_data",    int'(vdata), 8'h3C);
    chk("t6_latency", vcyc - fc, 156);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
